dec_nbit_seq: RTL and testbench

Parametrised, registered successor to the team's 2-to-4 gate-level decoder: converts an SEL_W-bit select into a one-hot output of 2**SEL_W lines. Each accepted code is held for a programmable number of cycles ("dwell") and then cleared. The `en` input is functional: it gates acceptance and aborts an active output. The block sits between control logic and strobe or chip-select consumers that need glitch-free, timed one-hot pulses.

---
 rtl/dec_nbit_pkg.sv | 12 +
 rtl/dec_dwell_cnt.sv | 38 +++
 rtl/dec_nbit_seq.sv | 174 +++++++++++++++++
 tb/tb_dec_nbit_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dec_nbit_pkg.sv
// Shared types for the timed one-hot decoder (dec_nbit_seq).
// Contents: the control FSM state encoding.
package dec_nbit_pkg;

    // SCAN is only reachable when the block is built with DEC_SCAN_EN.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

endpackage

// File: rtl/dec_dwell_cnt.sv
// Dwell counter shared by hold and scan steps.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clr         - force count to zero (abort / completion)
//   load        - load load_val (caller guarantees load_val >= 1)
//   load_val    - value to load
//   dec         - decrement enable; saturates at zero, never wraps
//   last_c      - combinational flag, count == 1 (final cycle of a dwell)
module dec_dwell_cnt #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               dec,
    output logic               last_c
);

    logic [DWELL_W-1:0] cnt;

    // Priority: clear, then load, then decrement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - DWELL_W'(1);
        end
    end

    assign last_c = (cnt == DWELL_W'(1));

endmodule

// File: rtl/dec_nbit_seq.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with programmable dwell.
// An accepted code drives a one-hot output for max(dwell,1) cycles, then
// clears with a one-cycle done pulse. en low blocks acceptance and aborts.
// Build option: define DEC_SCAN_EN to add the SCAN mode (walk every output
// line in order, each held for the sampled dwell).
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   en          - block enable
//   in_valid    - request strobe for sel/dwell
//   in_ready    - combinational, en && idle
//   sel         - code to decode, sampled on accept
//   dwell       - hold length in cycles (0 treated as 1), sampled on accept
//   scan_start  - start a scan (DEC_SCAN_EN builds only; ignored otherwise)
//   out         - registered one-hot output or zero
//   busy        - registered, high while not idle
//   done        - registered one-cycle pulse on normal completion
module dec_nbit_seq
    import dec_nbit_pkg::*;
#(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DWELL_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SEL_W-1:0]    sel,
    input  logic [DWELL_W-1:0]  dwell,
    input  logic                scan_start,
    output logic [2**SEL_W-1:0] out,
    output logic                busy,
    output logic                done
);

    localparam int unsigned OUT_W = 2**SEL_W;

    state_t             state, state_nxt;
    logic [OUT_W-1:0]   out_nxt;
    logic               done_nxt;
    logic [DWELL_W-1:0] dwell_eff;
    logic [DWELL_W-1:0] cnt_load_val;
    logic               cnt_load, cnt_dec, cnt_clr, cnt_last;

`ifdef DEC_SCAN_EN
    logic [SEL_W-1:0]   idx, idx_nxt;
    logic [DWELL_W-1:0] dwell_q, dwell_q_nxt;
`else
    logic               unused_scan_start;
    assign unused_scan_start = scan_start;
`endif

    // Zero dwell is promoted to one at load time so the counter never wraps.
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    assign in_ready = en && (state == IDLE);

    dec_dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .last_c   (cnt_last)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef DEC_SCAN_EN
            idx     <= '0;
            dwell_q <= '0;
`endif
        end else begin
            state <= state_nxt;
            out   <= out_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= done_nxt;
`ifdef DEC_SCAN_EN
            idx     <= idx_nxt;
            dwell_q <= dwell_q_nxt;
`endif
        end
    end

    // Next-state, next-output and counter control.
    always_comb begin
        state_nxt    = state;
        out_nxt      = out;
        done_nxt     = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_clr      = 1'b0;
        cnt_load_val = dwell_eff;
`ifdef DEC_SCAN_EN
        idx_nxt     = idx;
        dwell_q_nxt = dwell_q;
`endif
        case (state)
            IDLE: begin
                out_nxt = '0;
                // A plain request wins over a simultaneous scan_start.
                if (in_valid && in_ready) begin
                    out_nxt   = OUT_W'(1) << sel;
                    cnt_load  = 1'b1;
                    state_nxt = HOLD;
                end
`ifdef DEC_SCAN_EN
                else if (scan_start && in_ready) begin
                    out_nxt     = OUT_W'(1);
                    cnt_load    = 1'b1;
                    idx_nxt     = '0;
                    dwell_q_nxt = dwell_eff;
                    state_nxt   = SCAN;
                end
`endif
            end
            HOLD: begin
                // Abort has priority over completion.
                if (!en) begin
                    out_nxt   = '0;
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt_last) begin
                    out_nxt   = '0;
                    done_nxt  = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
`ifdef DEC_SCAN_EN
            SCAN: begin
                if (!en) begin
                    out_nxt   = '0;
                    cnt_clr   = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt_last) begin
                    // Last step is the all-ones index; no reliance on wrap.
                    if (idx == '1) begin
                        out_nxt   = '0;
                        done_nxt  = 1'b1;
                        cnt_clr   = 1'b1;
                        idx_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt      = idx + SEL_W'(1);
                        out_nxt      = out << 1;
                        cnt_load     = 1'b1;
                        cnt_load_val = dwell_q;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
`endif
            default: begin
                out_nxt   = '0;
                cnt_clr   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dec_nbit_seq.sv
// Scoreboard bench for dec_nbit_seq (SEL_W=2, DWELL_W=4).
// The driver pushes the hand-computed post-edge {out,busy,done,in_ready}
// for every cycle; an independent monitor pops and compares after each edge.
// Scan cases are included when DEC_SCAN_EN is defined.
module tb_dec_nbit_seq;

    localparam int unsigned SEL_W   = 2;
    localparam int unsigned DWELL_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   sel;
    logic [DWELL_W-1:0] dwell;
    logic               scan_start;
    logic [3:0]         out;
    logic               busy;
    logic               done;

    int n_tests = 0;
    int n_fail  = 0;
    int step_id = 0;

    logic [6:0] exp_q[$];
    int         id_q[$];

    dec_nbit_seq #(
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .dwell      (dwell),
        .scan_start (scan_start),
        .out        (out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the expected post-edge outputs.
    task automatic step(input logic e, input logic iv, input logic [1:0] s,
                        input logic [3:0] d, input logic ss,
                        input logic [3:0] eo, input logic eb, input logic ed,
                        input logic er);
        en         = e;
        in_valid   = iv;
        sel        = s;
        dwell      = d;
        scan_start = ss;
        @(posedge clk);
        step_id = step_id + 1;
        exp_q.push_back({eo, eb, ed, er});
        id_q.push_back(step_id);
        @(negedge clk);
    endtask

    // Monitor: compare every cycle for which an expectation exists.
    always begin
        logic [6:0] e;
        logic [6:0] a;
        int         id;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            a  = {out, busy, done, in_ready};
            n_tests = n_tests + 1;
            if (a !== e) begin
                n_fail = n_fail + 1;
                $display("FAIL step %0d: got out=%b busy=%b done=%b rdy=%b, want out=%b busy=%b done=%b rdy=%b",
                         id, a[6:3], a[2], a[1], a[0], e[6:3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        in_valid   = 1'b0;
        sel        = '0;
        dwell      = '0;
        scan_start = 1'b0;
        @(negedge clk);

        // Reset held with a pending request; en low keeps in_ready low.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 2'd1, 4'd2, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        // en low blocks acceptance.
        step(1'b0, 1'b1, 2'd2, 4'd3, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Single hold: sel=2, dwell=3.
        step(1'b1, 1'b1, 2'd2, 4'd3, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Dwell zero acts as one; back-to-back request in the done cycle.
        step(1'b1, 1'b1, 2'd3, 4'd0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 2'd1, 4'd2, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Abort: sel=0, dwell=10, en dropped in hold cycle 4.
        step(1'b1, 1'b1, 2'd0, 4'd10, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Abort beats completion on the final dwell cycle (dwell=1).
        step(1'b1, 1'b1, 2'd1, 4'd1, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Reset mid-hold: output clears, no done pulse.
        step(1'b1, 1'b1, 2'd3, 4'd5, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Maximum dwell (15) on sel=2.
        step(1'b1, 1'b1, 2'd2, 4'd15, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++)
            step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);

`ifdef DEC_SCAN_EN
        // Scan with dwell=2: each line held two cycles, then done.
        step(1'b1, 1'b0, 2'd0, 4'd2, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // in_valid and scan_start together: single hold only.
        step(1'b1, 1'b1, 2'd1, 4'd1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Scan abort on the second step.
        step(1'b1, 1'b0, 2'd0, 4'd1, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
`else
        // Without the scan build, scan_start is ignored.
        step(1'b1, 1'b0, 2'd0, 4'd2, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
`endif

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
